// File: rtl/taylor_cos_approx.sv
// taylor_cos_approx: sequential Q13.10 cosine via truncated Maclaurin series.
// Rev 1.0 - one multiply per cycle, MUL/SCALE loop per series term.
`default_nettype none

module taylor_cos_approx #(
  parameter int WIDTH     = 24,
  parameter int FRAC_BITS = 10,
  parameter int NUM_TERMS = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             ready_out,
  input  logic [WIDTH-1:0] angle_in,
  output logic [WIDTH-1:0] cos_out
);

  localparam int PW        = 48;
  localparam int ROM_W     = 21;
  localparam int ROM_SHIFT = 20;
  localparam logic [3:0] LAST_K = 4'(NUM_TERMS - 1);
  localparam logic signed [PW-1:0] ONE = 48'sd1 <<< FRAC_BITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SQUARE = 3'd1,
    MUL    = 3'd2,
    SCALE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [WIDTH-1:0] x;
  logic signed [PW-1:0]    x2;
  logic signed [PW-1:0]    term;
  logic signed [PW-1:0]    p;
  logic signed [PW-1:0]    sum;
  logic [3:0]              k;

  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] recip;
  logic signed [PW-1:0] sq_prod;
  logic signed [PW-1:0] mul_prod;
  logic signed [PW-1:0] scale_prod;

  // round(2^20 / ((2k-1)*2k)): turns term k-1 into term k after multiplying by x^2
  function automatic logic [ROM_W-1:0] recip_rom(input logic [3:0] idx);
    logic [ROM_W-1:0] val;
    case (idx)
      4'd1:    val = 21'd524288;
      4'd2:    val = 21'd87381;
      4'd3:    val = 21'd34953;
      4'd4:    val = 21'd18725;
      4'd5:    val = 21'd11651;
      4'd6:    val = 21'd7944;
      4'd7:    val = 21'd5761;
      default: val = 21'd0;
    endcase
    return val;
  endfunction

  always_comb begin
    x_ext      = {{(PW-WIDTH){x[WIDTH-1]}}, x};
    recip      = {{(PW-ROM_W){1'b0}}, recip_rom(k)};
    sq_prod    = x_ext * x_ext;
    mul_prod   = term * x2;
    scale_prod = p * recip;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SQUARE;
      SQUARE:  state_next = MUL;
      MUL:     state_next = SCALE;
      SCALE:   state_next = (k < LAST_K) ? MUL : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x         <= '0;
      x2        <= '0;
      term      <= '0;
      p         <= '0;
      sum       <= '0;
      k         <= '0;
      cos_out   <= '0;
      ready_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x         <= angle_in;
            ready_out <= 1'b0;
          end
        end
        SQUARE: begin
          x2   <= sq_prod >>> FRAC_BITS;
          term <= ONE;
          sum  <= ONE;
          k    <= 4'd1;
        end
        MUL: begin
          p <= mul_prod >>> FRAC_BITS;
        end
        SCALE: begin
          // the sign flip makes the series alternate
          term <= -(scale_prod >>> ROM_SHIFT);
          sum  <= sum - (scale_prod >>> ROM_SHIFT);
          k    <= k + 4'd1;
        end
        DONE: begin
          cos_out   <= sum[WIDTH-1:0];
          ready_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_taylor_cos_approx.sv
// tb_taylor_cos_approx: randomized self-checking bench against an arithmetic series model.
`default_nettype none

module tb_taylor_cos_approx;

  localparam int W = 24;
  localparam int N = 5;
  localparam int LAT = 2 * N;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  angle_in = '0;
  logic          ready_out;
  logic [W-1:0]  cos_out;

  int total = 0;
  int bad   = 0;

  taylor_cos_approx #(.WIDTH(W), .FRAC_BITS(10), .NUM_TERMS(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ready_out (ready_out),
    .angle_in  (angle_in),
    .cos_out   (cos_out)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap48(input longint v);
    longint t;
    t = v <<< 16;
    return t >>> 16;
  endfunction

  function automatic longint wrap24(input longint v);
    longint t;
    t = v <<< 40;
    return t >>> 40;
  endfunction

  function automatic longint recip_of(input int k);
    longint d;
    d = longint'((2 * k - 1) * (2 * k));
    return (((longint'(1) <<< 21) / d) + 1) / 2;
  endfunction

  // Series cos x = sum (-1)^k x^2k/(2k)!, each term built from the previous one
  function automatic longint model_cos(input longint ang);
    longint x2, term, p, sum;
    x2   = wrap48(ang * ang) >>> 10;
    term = 1024;
    sum  = 1024;
    for (int k = 1; k < N; k++) begin
      p    = wrap48(term * x2) >>> 10;
      term = -(wrap48(p * recip_of(k)) >>> 20);
      sum  = wrap48(sum + term);
    end
    return wrap24(sum);
  endfunction

  function automatic longint cos_s();
    return longint'($signed(cos_out));
  endfunction

  task automatic pulse(input longint ang);
    @(negedge clock);
    angle_in = ang[W-1:0];
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    angle_in = W'($urandom);
  endtask

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (ready_out) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run(input longint ang, output int lat, output longint res);
    pulse(ang);
    wait_ready(lat);
    res = cos_s();
  endtask

  initial begin
    int     lat;
    longint res;
    longint prev;
    longint ang;

    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_val("reset_ready", longint'(ready_out), 0);
    check_val("reset_cos", cos_s(), 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check_val("idle_ready", longint'(ready_out), 0);
    check_val("idle_cos", cos_s(), 0);

    run(0, lat, res);
    check_val("zero_lat", lat, LAT);
    check_val("zero_cos", res, 1024);

    run(1536, lat, res);
    check_val("a1536_lat", lat, LAT);
    check_val("a1536_cos", res, 73);
    check_val("a1536_model", res, model_cos(1536));
    repeat (3) @(negedge clock);
    check_val("hold_ready", longint'(ready_out), 1);
    check_val("hold_cos", cos_s(), 73);

    pulse(1024);
    check_val("start_drops_ready", longint'(ready_out), 0);
    check_val("start_keeps_cos", cos_s(), 73);
    wait_ready(lat);
    check_val("a1024_lat", lat, LAT);
    check_val("a1024_cos", cos_s(), 555);

    run(-1536, lat, res);
    check_val("neg1536_lat", lat, LAT);
    check_val("neg1536_cos", res, 73);

    // second start 4 cycles into a computation must be ignored
    pulse(1536);
    repeat (3) @(negedge clock);
    angle_in = W'(0);
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    wait_ready(lat);
    check_val("busy_start_lat", lat, LAT - 4);
    check_val("busy_start_cos", cos_s(), 73);

    // start held at the DONE edge must not launch a new evaluation
    pulse(1024);
    repeat (LAT - 1) @(negedge clock);
    angle_in = W'(0);
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    check_val("done_edge_ready", longint'(ready_out), 1);
    check_val("done_edge_cos", cos_s(), 555);
    repeat (12) @(negedge clock);
    check_val("done_edge_no_rerun", longint'(ready_out), 1);
    check_val("done_edge_cos_hold", cos_s(), 555);

    pulse(1024);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_val("abort_ready", longint'(ready_out), 0);
    check_val("abort_cos", cos_s(), 0);
    reset = 1'b1;
    repeat (LAT + 3) @(negedge clock);
    check_val("abort_no_stale", longint'(ready_out), 0);
    run(1536, lat, res);
    check_val("after_abort_lat", lat, LAT);
    check_val("after_abort_cos", res, 73);

    for (int i = 0; i < 24; i++) begin
      ang = longint'($urandom_range(8192, 0)) - 4096;
      run(ang, lat, res);
      check_val($sformatf("rand%0d_lat", i), lat, LAT);
      check_val($sformatf("rand%0d_cos(%0d)", i, ang), res, model_cos(ang));
      if (i % 4 == 0) begin
        prev = res;
        run(-ang, lat, res);
        check_val($sformatf("rand%0d_even", i), res, prev);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
